// File: rtl/pal_line_fetch_ctrl.sv
// Framebuffer row fetch and pixel serialiser for the PAL transmitter.
// One BRAM read per active line, then PIXELS bits shifted out at PIXEL_TICKS cycles each.
module pal_line_fetch_ctrl #(
  parameter int PIXELS       = 300,
  parameter int PIXEL_TICKS  = 27,
  parameter int ACTIVE_START = 1900,
  parameter int LINE_TICKS   = 10176,
  parameter int RD_LAT       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_en,
  input  logic              line_start,
  input  logic [9:0]        line_num,
  output logic              bram_rd_en,
  output logic [9:0]        bram_addr_rd,
  input  logic [PIXELS-1:0] bram_data_rd,
  output logic              pixel_valid,
  output logic              pixel_white,
  output logic              line_busy
);

  localparam int TICK_W = 14;
  localparam int PIX_W  = 9;
  localparam int SUB_W  = 5;

  if (ACTIVE_START <= RD_LAT + 2) begin : g_bad_active_start
    $error("ACTIVE_START must exceed RD_LAT+2");
  end
  if (ACTIVE_START + PIXELS * PIXEL_TICKS > LINE_TICKS) begin : g_bad_line_len
    $error("active video does not fit in LINE_TICKS");
  end

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_ACTIVE,
    SHIFT,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [SUB_W-1:0]    sub_q, sub_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic [PIXELS-1:0]   shreg_q, shreg_d;
  logic [9:0]          addr_q, addr_d;
  logic                rd_en_q, rd_en_d;
  logic                valid_q, valid_d;
  logic                white_q, white_d;

  logic                row_ok;
  logic [9:0]          row;

  // Interlaced mapping: field 1 fills even rows, field 2 fills odd rows.
  function automatic logic [10:0] map_row(input logic [9:0] ln);
    logic [9:0] r;
    logic       ok;
    r  = '0;
    ok = 1'b0;
    if (ln >= 10'd23 && ln <= 10'd310) begin
      ok = 1'b1;
      r  = (ln - 10'd23) << 1;
    end else if (ln >= 10'd336 && ln <= 10'd623) begin
      ok = 1'b1;
      r  = ((ln - 10'd336) << 1) | 10'd1;
    end
    return {ok, r};
  endfunction

  assign {row_ok, row} = map_row(line_num);

  always_comb begin
    state_d = state_q;
    tick_d  = (tick_q == TICK_W'(LINE_TICKS)) ? tick_q : tick_q + 1'b1;
    sub_d   = sub_q;
    pix_d   = pix_q;
    shreg_d = shreg_q;
    addr_d  = addr_q;
    rd_en_d = 1'b0;
    valid_d = 1'b0;
    white_d = 1'b0;

    if (line_start) begin
      tick_d = '0;
      sub_d  = '0;
      pix_d  = '0;
      if (frame_en && row_ok) begin
        addr_d  = row;
        rd_en_d = 1'b1;
        state_d = FETCH;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        FETCH: begin
          // sub_q doubles as the read-latency counter before pixels start
          if (sub_q == SUB_W'(RD_LAT)) begin
            shreg_d = bram_data_rd;
            sub_d   = '0;
            state_d = WAIT_ACTIVE;
          end else begin
            sub_d = sub_q + 1'b1;
          end
        end
        WAIT_ACTIVE: begin
          // tick_q lags the line cycle by one, so this fires to show pixel 0 at ACTIVE_START+1
          if (tick_q >= TICK_W'(ACTIVE_START - 1)) begin
            state_d = SHIFT;
            sub_d   = '0;
            pix_d   = '0;
            valid_d = 1'b1;
            white_d = shreg_q[0];
          end
        end
        SHIFT: begin
          valid_d = 1'b1;
          white_d = white_q;
          if (sub_q == SUB_W'(PIXEL_TICKS - 1)) begin
            sub_d = '0;
            if (pix_q == PIX_W'(PIXELS - 1)) begin
              state_d = DONE;
              valid_d = 1'b0;
              white_d = 1'b0;
            end else begin
              pix_d   = pix_q + 1'b1;
              shreg_d = shreg_q >> 1;
              white_d = shreg_q[1];
            end
          end else begin
            sub_d = sub_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      sub_q   <= '0;
      pix_q   <= '0;
      shreg_q <= '0;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      valid_q <= 1'b0;
      white_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      sub_q   <= sub_d;
      pix_q   <= pix_d;
      shreg_q <= shreg_d;
      addr_q  <= addr_d;
      rd_en_q <= rd_en_d;
      valid_q <= valid_d;
      white_q <= white_d;
    end
  end

  assign bram_rd_en   = rd_en_q;
  assign bram_addr_rd = addr_q;
  assign pixel_valid  = valid_q;
  assign pixel_white  = white_q;
  assign line_busy    = (state_q == FETCH) || (state_q == WAIT_ACTIVE) || (state_q == SHIFT);

endmodule

// File: tb/tb_pal_line_fetch_ctrl.sv
// Scoreboard bench for pal_line_fetch_ctrl: line descriptors and expected reads are queued
// at stimulus time and compared cycle by cycle against the line timing.
module tb_pal_line_fetch_ctrl;

  localparam int AS  = 1900;
  localparam int PT  = 27;
  localparam int PIX = 300;
  localparam int LT  = 10176;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           frame_en;
  logic           line_start;
  logic [9:0]     line_num;
  logic           bram_rd_en;
  logic [9:0]     bram_addr_rd;
  logic [PIX-1:0] bram_data_rd;
  logic           pixel_valid;
  logic           pixel_white;
  logic           line_busy;
  logic [PIX-1:0] cur_pat;

  pal_line_fetch_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_en     (frame_en),
    .line_start   (line_start),
    .line_num     (line_num),
    .bram_rd_en   (bram_rd_en),
    .bram_addr_rd (bram_addr_rd),
    .bram_data_rd (bram_data_rd),
    .pixel_valid  (pixel_valid),
    .pixel_white  (pixel_white),
    .line_busy    (line_busy)
  );

  always #5 clk = ~clk;

  // One-cycle-latency BRAM: data is only correct in the cycle after the strobe.
  always @(posedge clk) bram_data_rd <= bram_rd_en ? cur_pat : ~cur_pat;

  typedef struct {
    int             ln;
    bit             active;
    bit [PIX-1:0]   pat;
    int             len;
    int             rst_at;
    int             nv;
  } line_t;

  line_t      lq[$];
  logic [9:0] rdq[$];
  line_t      cur;
  bit         have = 1'b0;
  int         cyc, err_rd, err_v, err_w, err_b, nv_seen;
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic finalize();
    chk($sformatf("L%0d rd_strobe_errs", cur.ln), err_rd, 0);
    chk($sformatf("L%0d valid_errs", cur.ln), err_v, 0);
    chk($sformatf("L%0d white_errs", cur.ln), err_w, 0);
    chk($sformatf("L%0d busy_errs", cur.ln), err_b, 0);
    chk($sformatf("L%0d valid_cycles", cur.ln), nv_seen, cur.nv);
  endtask

  always @(negedge clk) begin
    if (line_start) begin
      if (have) finalize();
      if (lq.size() == 0) begin
        chk("line_queue_nonempty", 0, 1);
        have = 1'b0;
      end else begin
        cur  = lq.pop_front();
        have = 1'b1;
      end
      cyc = 0; err_rd = 0; err_v = 0; err_w = 0; err_b = 0; nv_seen = 0;
    end else if (have) begin
      bit live, e_v, e_w, e_b, e_rd;
      cyc++;
      live = (cur.rst_at == 0) || (cyc < cur.rst_at);
      e_v  = cur.active && live && cyc >= AS + 1 && cyc <= AS + PIX * PT;
      e_w  = 1'b0;
      if (e_v) e_w = cur.pat[(cyc - AS - 1) / PT];
      e_b  = cur.active && live && cyc <= AS + PIX * PT;
      e_rd = cur.active && live && cyc == 1;
      if (pixel_valid !== e_v) err_v++;
      if (pixel_white !== e_w) err_w++;
      if (line_busy !== e_b) err_b++;
      if (bram_rd_en !== e_rd) err_rd++;
      if (pixel_valid === 1'b1) nv_seen++;
      if (bram_rd_en === 1'b1) begin
        if (rdq.size() == 0) err_rd++;
        else chk($sformatf("L%0d rd_addr", cur.ln), 32'(bram_addr_rd), 32'(rdq.pop_front()));
      end
    end
  end

  function automatic logic [PIX-1:0] rpat();
    logic [319:0] t;
    t = '0;
    for (int i = 0; i < 10; i++) t = (t << 32) | 320'($urandom);
    return t[PIX-1:0];
  endfunction

  task automatic run_line(input int ln, input bit en, input logic [PIX-1:0] pat,
                          input int len, input int drop_at, input int rst_at);
    line_t d;
    int    last;
    bit    in_f1, in_f2;
    in_f1    = ln >= 23 && ln <= 310;
    in_f2    = ln >= 336 && ln <= 623;
    d.ln     = ln;
    d.active = en && (in_f1 || in_f2);
    d.pat    = pat;
    d.len    = len;
    d.rst_at = rst_at;
    last = (len - 1 < 10000) ? len - 1 : 10000;
    if (rst_at > 0 && rst_at - 1 < last) last = rst_at - 1;
    d.nv = (d.active && last > AS) ? last - AS : 0;
    lq.push_back(d);
    if (d.active) rdq.push_back(in_f1 ? 10'((ln - 23) * 2) : 10'((ln - 336) * 2 + 1));
    cur_pat    = pat;
    line_num   = 10'(ln);
    frame_en   = en;
    line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    for (int c = 1; c < len; c++) begin
      if (c == drop_at) frame_en = 1'b0;
      if (rst_at > 0 && c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst valid", 32'(pixel_valid), 0);
        chk("async_rst white", 32'(pixel_white), 0);
        chk("async_rst busy", 32'(line_busy), 0);
        chk("async_rst rd_en", 32'(bram_rd_en), 0);
        chk("async_rst addr", 32'(bram_addr_rd), 0);
      end
      if (rst_at > 0 && c == rst_at + 5) rst_n = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [PIX-1:0] one, alt;
    one        = '0;
    one[0]     = 1'b1;
    alt        = {150{2'b01}};
    rst_n      = 1'b0;
    frame_en   = 1'b0;
    line_start = 1'b0;
    line_num   = '0;
    cur_pat    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset valid", 32'(pixel_valid), 0);
    chk("reset white", 32'(pixel_white), 0);
    chk("reset busy", 32'(line_busy), 0);
    chk("reset rd_en", 32'(bram_rd_en), 0);
    chk("reset addr", 32'(bram_addr_rd), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_line(23, 1'b1, one, LT, 0, 0);
    run_line(336, 1'b1, rpat(), 2100, 0, 0);
    run_line(310, 1'b1, rpat(), 2100, 0, 0);
    run_line(623, 1'b1, rpat(), 2100, 0, 0);
    run_line(1, 1'b1, rpat(), 2100, 0, 0);
    run_line(22, 1'b1, rpat(), 2100, 0, 0);
    run_line(311, 1'b1, rpat(), 2100, 0, 0);
    run_line(335, 1'b1, rpat(), 2100, 0, 0);
    run_line(624, 1'b1, rpat(), 2100, 0, 0);
    run_line(100, 1'b1, alt, LT, 0, 0);
    run_line(200, 1'b1, rpat(), 5000, 0, 0);
    run_line(201, 1'b1, rpat(), LT, 0, 0);
    run_line(50, 1'b0, rpat(), 2100, 0, 0);
    run_line(60, 1'b1, rpat(), LT, 3000, 0);
    run_line(61, 1'b0, rpat(), 2100, 0, 0);
    run_line(70, 1'b1, rpat(), 6000, 0, 4000);
    run_line(71, 1'b1, rpat(), 2100, 0, 0);

    if (have) finalize();
    have = 1'b0;
    chk("pending_reads", rdq.size(), 0);
    chk("pending_lines", lq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
